regbus_arb: RTL

REGBUS_ARB -- requirements
Module: regbus_arb

---
 rtl/regbus_pkg.sv | 19 +
 rtl/regbus_arb.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/regbus_pkg.sv
// Shared widths and encodings for the register-bus arbiter.
package regbus_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RDW  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/regbus_arb.sv
// Two-master register bus arbiter: port A is a fire-and-forget strobe interface
// buffered in holding registers, port B is a req/ack master; one target port.
module regbus_arb
    import regbus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic              a_re,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdat,
    output logic [DATA_W-1:0] a_rdat,
    output logic              a_rvalid,
    output logic              a_ovf,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdat,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdat,
    output logic              m_we,
    output logic              m_re,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdat,
    input  logic [DATA_W-1:0] m_rdat
);

    state_t              state_reg;
    owner_t              owner_reg;
    owner_t              last_owner_reg;
    logic                wpend_reg;
    logic                rpend_reg;
    logic [ADDR_W-1:0]   w_addr_reg;
    logic [DATA_W-1:0]   w_data_reg;
    logic [ADDR_W-1:0]   r_addr_reg;

    logic b_busy;
    logic b_visible;
    logic w_consume;
    logic r_consume;
    logic grant_b;
    logic grant_aw;
    logic grant_ar;

    // B stays invisible through its own ack cycle, since the master only drops
    // b_req after seeing b_ack.
    always_comb begin
        b_busy    = b_ack || (state_reg != ST_IDLE && owner_reg == OWN_B);
        b_visible = b_req && !b_busy;
        w_consume = (state_reg == ST_WR)  && (owner_reg == OWN_A);
        r_consume = (state_reg == ST_RDW) && (owner_reg == OWN_A);
        grant_b   = b_visible && (last_owner_reg == OWN_A || (!wpend_reg && !rpend_reg));
        grant_aw  = !grant_b && wpend_reg;
        grant_ar  = !grant_b && !wpend_reg && rpend_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_B;
            last_owner_reg <= OWN_B;
            wpend_reg      <= 1'b0;
            rpend_reg      <= 1'b0;
            w_addr_reg     <= '0;
            w_data_reg     <= '0;
            r_addr_reg     <= '0;
            a_rdat         <= '0;
            a_rvalid       <= 1'b0;
            a_ovf          <= 1'b0;
            b_ack          <= 1'b0;
            b_rdat         <= '0;
            m_we           <= 1'b0;
            m_re           <= 1'b0;
            m_addr         <= '0;
            m_wdat         <= '0;
        end else begin
            m_we     <= 1'b0;
            m_re     <= 1'b0;
            a_rvalid <= 1'b0;
            b_ack    <= 1'b0;

            // A capture wins over the consume that happens in the same cycle.
            if (a_we) begin
                w_addr_reg <= a_addr;
                w_data_reg <= a_wdat;
                wpend_reg  <= 1'b1;
                if (wpend_reg && !w_consume)
                    a_ovf <= 1'b1;
            end else if (w_consume) begin
                wpend_reg <= 1'b0;
            end

            if (a_re) begin
                r_addr_reg <= a_addr;
                rpend_reg  <= 1'b1;
                if (rpend_reg && !r_consume)
                    a_ovf <= 1'b1;
            end else if (r_consume) begin
                rpend_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (grant_b) begin
                        owner_reg      <= OWN_B;
                        last_owner_reg <= OWN_B;
                        m_addr         <= b_addr;
                        m_wdat         <= b_wdat;
                        if (b_we) begin
                            state_reg <= ST_WR;
                            m_we      <= 1'b1;
                        end else begin
                            state_reg <= ST_RD;
                            m_re      <= 1'b1;
                        end
                    end else if (grant_aw) begin
                        owner_reg      <= OWN_A;
                        last_owner_reg <= OWN_A;
                        m_addr         <= w_addr_reg;
                        m_wdat         <= w_data_reg;
                        state_reg      <= ST_WR;
                        m_we           <= 1'b1;
                    end else if (grant_ar) begin
                        owner_reg      <= OWN_A;
                        last_owner_reg <= OWN_A;
                        m_addr         <= r_addr_reg;
                        state_reg      <= ST_RD;
                        m_re           <= 1'b1;
                    end
                end
                ST_WR: begin
                    state_reg <= ST_IDLE;
                    if (owner_reg == OWN_B)
                        b_ack <= 1'b1;
                end
                ST_RD: begin
                    state_reg <= ST_RDW;
                end
                ST_RDW: begin
                    state_reg <= ST_IDLE;
                    if (owner_reg == OWN_A) begin
                        a_rdat   <= m_rdat;
                        a_rvalid <= 1'b1;
                    end else begin
                        b_rdat <= m_rdat;
                        b_ack  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
